fifo_reader: RTL

Read-side controller for the clock-domain-crossing buffer: drains words from the FIFO read port in the `clk_2` domain and presents each one on a registered output for a programmable dwell time. It also raises a valid flag, generates even parity, and counts consumed words. It sits between the buffer wrapper's read port and the display/parity logic. A `flush` input lets the top-level FSM empty the buffer quickly on stop.

---
 rtl/trab3_pkg.sv | 24 ++
 rtl/dwell_counter.sv | 34 +++
 rtl/fifo_reader.sv | 90 +++++++++
 3 files changed

// File: rtl/trab3_pkg.sv
// rtl/trab3_pkg.sv - shared types, constants and parity helper for the trab3 read path
package trab3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } rd_state_t;

  localparam int DATA_W_DEF   = 16;
  localparam int PARITY_MAX_W = 64;

  // Callers zero-extend narrower words; padding zeros do not change the XOR.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

  // Dwell counter only ever holds HOLD_CYCLES-1, so clog2 bits suffice.
  function automatic int dwell_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - loadable down-counter timing how long each word is displayed
module dwell_counter
  import trab3_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [dwell_width(HOLD_CYCLES)-1:0] load_val,
  input  logic                               en,
  input  logic                               force_zero,
  output logic                               zero
);

  localparam int CW = dwell_width(HOLD_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (force_zero) begin
      cnt <= '0;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - pops FIFO words and presents each for a programmable dwell time
module fifo_reader
  import trab3_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy
);

  localparam int DW_W = dwell_width(HOLD_CYCLES);

  rd_state_t       state;
  logic            go;
  logic            dwell_zero;
  logic [DW_W-1:0] dwell_val;

  assign go        = (enable | flush) & ~empty;
  assign dwell_val = flush ? '0 : DW_W'(HOLD_CYCLES - 1);
  assign busy      = (state != ST_IDLE);

  // A flush seen while holding collapses the remaining dwell to a single cycle.
  dwell_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_LATCH),
    .load_val  (dwell_val),
    .en        (state == ST_HOLD),
    .force_zero((state == ST_HOLD) & flush),
    .zero      (dwell_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_en      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity     <= 1'b0;
      rd_count   <= '0;
    end else begin
      rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state <= ST_POP;
            rd_en <= 1'b1;
          end
        end
        ST_POP: begin
          state <= ST_LATCH;
        end
        ST_LATCH: begin
          data_out   <= rd_data;
          parity     <= even_parity(PARITY_MAX_W'(rd_data));
          rd_count   <= rd_count + CNT_W'(1);
          data_valid <= 1'b1;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (dwell_zero) begin
            data_valid <= 1'b0;
            if (go) begin
              state <= ST_POP;
              rd_en <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
